// File: rtl/leitor_senha_pkg.sv
// Shared types and bank geometry for the lock-code reader.
// The reader drives one read port of the 8x8 register bank.
package leitor_senha_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 3;
   localparam int BUF_DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      RESULT,
      LOCKOUT
   } state_t;

endpackage

// File: rtl/contador_bloqueio.sv
// Loadable down-counter that times the lockout period.
// The done flag is high whenever the count has reached zero.
module contador_bloqueio #(
   parameter int LOAD_VALUE = 999,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_done
);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state is always written with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CNT_W'(LOAD_VALUE);
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/leitor_senha.sv
// Buffers keypad digits, compares them against bank registers 1..N_DIGITS,
// and pulses open/fail while tracking failed attempts with a timed lockout.
module leitor_senha
   import leitor_senha_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              digit_valid,
   input  logic [DATA_W-1:0] digit,
   input  logic              check,
   output logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] rd,
   output logic              busy,
   output logic              open,
   output logic              fail,
   output logic              locked,
   output logic [1:0]        tries_left
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_DIGITS);
   localparam logic [1:0]        TRIES_INIT = 2'(MAX_TRIES);
   localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ra;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_buf [BUF_DEPTH];
   logic              r_mismatch;
   logic              r_busy;
   logic              r_open;
   logic              r_fail;
   logic              r_locked;
   logic [1:0]        r_tries_left;

   logic [ADDR_W-1:0] w_idx;
   logic              w_digit_differs;
   logic              w_lock_entry;
   logic              w_lock_run;
   logic              w_lock_done;

   // Address r_ra maps to typed digit r_ra-1; rd is used live, no snapshot.
   assign w_idx           = r_ra - ADDR_W'(1);
   assign w_digit_differs = (rd != r_buf[w_idx]);
   assign w_lock_entry    = (r_state == RESULT) && r_mismatch && (r_tries_left == 2'd1);
   assign w_lock_run      = (r_state == LOCKOUT);

   contador_bloqueio #(
      .LOAD_VALUE (LOCKOUT_CYCLES - 1),
      .CNT_W      (LOCK_W)
   ) u_contador_bloqueio (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_lock_entry),
      .i_en   (w_lock_run),
      .o_done (w_lock_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ra         <= '0;
         r_cnt        <= '0;
         r_mismatch   <= 1'b0;
         r_busy       <= 1'b0;
         r_open       <= 1'b0;
         r_fail       <= 1'b0;
         r_locked     <= 1'b0;
         r_tries_left <= TRIES_INIT;
         // NOTE: the digit buffer is reset explicitly so no stale code survives.
         for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      end else begin
         r_open <= 1'b0;
         r_fail <= 1'b0;
         case (r_state)
            IDLE: begin
               if (check) begin
                  if (r_cnt == LAST_ADDR) begin
                     r_state    <= COMPARE;
                     r_ra       <= ADDR_W'(1);
                     r_mismatch <= 1'b0;
                     r_busy     <= 1'b1;
                  end else begin
                     r_state    <= RESULT;
                     r_mismatch <= 1'b1;
                  end
               end else if (digit_valid && (r_cnt != LAST_ADDR)) begin
                  r_buf[r_cnt] <= digit;
                  r_cnt        <= r_cnt + ADDR_W'(1);
               end
            end
            COMPARE: begin
               // Every digit is always visited so timing never leaks the code.
               r_mismatch <= r_mismatch | w_digit_differs;
               if (r_ra == LAST_ADDR) begin
                  r_state <= RESULT;
                  r_ra    <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_ra <= r_ra + ADDR_W'(1);
               end
            end
            RESULT: begin
               if (r_mismatch) begin
                  r_fail       <= 1'b1;
                  r_tries_left <= r_tries_left - 2'd1;
               end else begin
                  r_open       <= 1'b1;
                  r_tries_left <= TRIES_INIT;
               end
               r_cnt <= '0;
               for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
               if (w_lock_entry) begin
                  r_state  <= LOCKOUT;
                  r_locked <= 1'b1;
                  r_busy   <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            LOCKOUT: begin
               if (w_lock_done) begin
                  r_state      <= IDLE;
                  r_locked     <= 1'b0;
                  r_busy       <= 1'b0;
                  r_tries_left <= TRIES_INIT;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ra         = r_ra;
   assign busy       = r_busy;
   assign open       = r_open;
   assign fail       = r_fail;
   assign locked     = r_locked;
   assign tries_left = r_tries_left;

endmodule

// File: tb/tb_leitor_senha.sv
// Scoreboard bench for leitor_senha: a transaction-level model predicts each
// open/fail pulse, its cycle and tries_left, plus ra/busy/locked windows.
module tb_leitor_senha;

   localparam int N  = 4;
   localparam int MT = 3;
   localparam int L  = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic       digit_valid;
   logic [7:0] digit;
   logic       check;
   logic [2:0] ra;
   logic [7:0] rd;
   logic       busy;
   logic       open;
   logic       fail;
   logic       locked;
   logic [1:0] tries_left;

   logic [7:0] bank [8];
   assign rd = bank[ra];

   always #5 clk = ~clk;

   leitor_senha #(
      .N_DIGITS       (N),
      .MAX_TRIES      (MT),
      .LOCKOUT_CYCLES (L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_valid (digit_valid),
      .digit       (digit),
      .check       (check),
      .ra          (ra),
      .rd          (rd),
      .busy        (busy),
      .open        (open),
      .fail        (fail),
      .locked      (locked),
      .tries_left  (tries_left)
   );

   typedef struct {
      bit ok;
      int tries;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   edge_n  = 0;
   bit   mon_en  = 1'b0;

   int   m_entry[$];
   int   m_tries       = MT;
   int   blocked_until = 0;
   int   cmp_start     = -1000;
   int   lock_first    = -1000;
   int   lock_last     = -1001;
   int   stim_q[$];

   task automatic check_eq(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, edge_n);
      end
   endtask

   function automatic void model_reset(input int e);
      m_entry.delete();
      exp_q.delete();
      m_tries       = MT;
      blocked_until = e;
      cmp_start     = -1000;
      lock_first    = -1000;
      lock_last     = -1001;
   endfunction

   // Inputs sampled at edge e; the model decides acceptance and the outcome.
   function automatic void model_step(input int e, input bit dv, input int d, input bit ck);
      bit   ok;
      int   p;
      exp_t x;
      if (e <= blocked_until) return;
      if (ck) begin
         if (m_entry.size() == N) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (m_entry[i] != int'(bank[i+1])) ok = 1'b0;
            p = e + N + 1;
            cmp_start = e;
         end else begin
            ok = 1'b0;
            p = e + 1;
         end
         m_tries = ok ? MT : m_tries - 1;
         x.ok = ok; x.tries = m_tries; x.cyc = p;
         exp_q.push_back(x);
         m_entry.delete();
         blocked_until = p;
         if (m_tries == 0) begin
            lock_first    = p;
            lock_last     = p + L - 1;
            blocked_until = p + L;
            m_tries       = MT;
         end
      end else if (dv && m_entry.size() < N) begin
         m_entry.push_back(d & 255);
      end
   endfunction

   task automatic tick(input bit dv, input int d, input bit ck, input bit r = 1'b0);
      @(negedge clk);
      rst         = r;
      digit_valid = dv;
      digit       = 8'(d);
      check       = ck;
      @(posedge clk);
      edge_n++;
      if (r) model_reset(edge_n);
      else   model_step(edge_n, dv, d, ck);
   endtask

   task automatic noise_tick();
      tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 9)), bit'($urandom_range(0, 1)));
   endtask

   // Keep poking inputs while the block should be ignoring them.
   task automatic drain();
      while (edge_n + 1 <= blocked_until) noise_tick();
      tick(1'b0, 0, 1'b0);
   endtask

   task automatic enter_stim();
      foreach (stim_q[i]) tick(1'b1, stim_q[i], 1'b0);
   endtask

   task automatic do_check();
      tick(1'b0, 0, 1'b1);
      drain();
   endtask

   task automatic try_code();
      enter_stim();
      do_check();
   endtask

   // Monitor: pops the scoreboard on each pulse, checks ra/busy/locked windows.
   always @(negedge clk) begin
      int   c;
      bit   in_cmp;
      bit   in_lock;
      exp_t e;
      if (mon_en) begin
         c       = edge_n;
         in_cmp  = (c >= cmp_start) && (c <= cmp_start + N - 1);
         in_lock = (c >= lock_first) && (c <= lock_last);
         check_eq("ra", int'(ra), in_cmp ? c - cmp_start + 1 : 0);
         check_eq("busy", int'(busy), int'(in_cmp || in_lock));
         check_eq("locked", int'(locked), int'(in_lock));
         if (c == lock_last + 1) check_eq("tries_after_lockout", int'(tries_left), MT);
         if (open || fail) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("pulse_cycle", c, e.cyc);
               check_eq("open", int'(open), int'(e.ok));
               check_eq("fail", int'(fail), int'(!e.ok));
               check_eq("tries_left", int'(tries_left), e.tries);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= c) begin
            e = exp_q.pop_front();
            check_eq("pulse_missing", 0, 1);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; digit_valid = 1'b0; digit = '0; check = 1'b0;
      foreach (bank[i]) bank[i] = '0;
      bank[1] = 8'd3; bank[2] = 8'd1; bank[3] = 8'd4; bank[4] = 8'd1;

      repeat (3) tick(1'b0, 0, 1'b0, 1'b1);
      #1;
      check_eq("reset_ra", int'(ra), 0);
      check_eq("reset_busy", int'(busy), 0);
      check_eq("reset_open", int'(open), 0);
      check_eq("reset_fail", int'(fail), 0);
      check_eq("reset_locked", int'(locked), 0);
      check_eq("reset_tries", int'(tries_left), MT);
      mon_en = 1'b1;
      tick(1'b0, 0, 1'b0);

      // Correct code, wrong last digit, recovery, short entry.
      stim_q = '{3, 1, 4, 1}; try_code();
      stim_q = '{3, 1, 4, 2}; try_code();
      stim_q = '{3, 1, 4, 1}; try_code();
      stim_q = '{3, 1};       try_code();

      // Restore tries, then three wrong codes into lockout.
      stim_q = '{3, 1, 4, 1}; try_code();
      stim_q = '{9, 1, 4, 1}; try_code();
      stim_q = '{3, 9, 4, 1}; try_code();
      stim_q = '{3, 1, 4, 0}; try_code();

      // Fifth digit ignored; digit dropped when check is in the same cycle.
      stim_q = '{3, 1, 4, 1, 9}; try_code();
      stim_q = '{3, 1, 4};       enter_stim();
      tick(1'b1, 1, 1'b1);
      drain();

      // Reset during the second COMPARE cycle.
      stim_q = '{3, 1, 4, 1}; enter_stim();
      tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0, 1'b1);
      #1;
      check_eq("midreset_ra", int'(ra), 0);
      check_eq("midreset_busy", int'(busy), 0);
      check_eq("midreset_tries", int'(tries_left), MT);
      check_eq("midreset_open", int'(open), 0);
      check_eq("midreset_fail", int'(fail), 0);
      tick(1'b0, 0, 1'b0);
      do_check();

      // Randomized transactions with a changing bank.
      for (int k = 0; k < 60; k++) begin
         int n_dig;
         for (int j = 1; j <= N; j++) bank[j] = 8'($urandom_range(0, 3));
         stim_q.delete();
         if ($urandom_range(0, 9) < 6) begin
            for (int j = 1; j <= N; j++) stim_q.push_back(int'(bank[j]));
            if ($urandom_range(0, 1) == 1) stim_q[$urandom_range(0, N - 1)] = int'($urandom_range(0, 3));
         end else begin
            n_dig = int'($urandom_range(0, N + 1));
            for (int j = 0; j < n_dig; j++) stim_q.push_back(int'($urandom_range(0, 3)));
         end
         foreach (stim_q[i]) begin
            tick(1'b1, stim_q[i], 1'b0);
            if ($urandom_range(0, 3) == 0) tick(1'b0, 0, 1'b0);
         end
         if ($urandom_range(0, 4) == 0) tick(1'b1, int'($urandom_range(0, 3)), 1'b1);
         else                           tick(1'b0, 0, 1'b1);
         drain();
      end

      repeat (N + 3) tick(1'b0, 0, 1'b0);
      check_eq("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/leitor_senha.md
Name: leitor_senha

Overview:
- Reader side of the 8x8 register bank. The bank's write port is loaded with the stored lock code. This block drives one bank read port (address out, data in).
- It buffers digits typed by the user, then on request scans bank registers 1..N_DIGITS and compares each against the typed digit.
- It pulses open or fail and manages a failed-attempt counter with a timed lockout.
- It sits between the keypad front-end and the lock actuator.

Parameters:
- N_DIGITS, 4, code length; registers 1..N_DIGITS hold the code; legal 1..7.
- MAX_TRIES, 3, failed checks allowed before lockout; legal 1..3.
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles; legal ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- digit_valid  in  1  one-cycle strobe: digit is a new keypad entry.
- digit  in  8  entered digit value.
- check  in  1  one-cycle strobe: compare buffered entry against stored code.
- ra  out  3  read address to bank read port.
- rd  in  8  bank read data; combinational w.r.t. ra, same cycle.
- busy  out  1  high in COMPARE and LOCKOUT.
- open  out  1  one-cycle pulse on correct code.
- fail  out  1  one-cycle pulse on wrong code or wrong length.
- locked  out  1  high during lockout.
- tries_left  out  2  remaining attempts before lockout.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE, ra=0, busy=0, open=0, fail=0, locked=0, tries_left=MAX_TRIES, entry count=0, digit buffer cleared, mismatch flag=0.
- Reset mid-COMPARE or mid-LOCKOUT: abort immediately; no open/fail pulse is produced.
- States: IDLE, COMPARE, RESULT, LOCKOUT. All outputs are registered.
- IDLE, digit entry:
  - digit_valid stores digit into buf[cnt] and increments cnt.
  - At cnt==N_DIGITS, further digits are ignored; cnt saturates.
- IDLE, check with cnt==N_DIGITS: go to COMPARE with ra=1 and mismatch=0.
- IDLE, check with cnt≠N_DIGITS (including 0): go straight to RESULT with mismatch=1.
- check and digit_valid in the same cycle: check wins; that digit is dropped.
- COMPARE:
  - Each cycle, mismatch |= (rd != buf[ra-1]).
  - If ra==N_DIGITS, go to RESULT; otherwise ra++.
  - There is no early exit: comparison time is constant and independent of the data.
  - digit_valid and check are ignored.
- RESULT (one cycle, then exit):
  - If mismatch=0: open=1 for that cycle, tries_left=MAX_TRIES.
  - If mismatch=1: fail=1 for that cycle, tries_left-1.
  - Buffer and cnt are cleared; ra returns to 0.
  - Next state is LOCKOUT if tries_left reaches 0, otherwise IDLE.
- Latency: check sampled at edge t gives the open/fail pulse in cycle t+N_DIGITS+1. The wrong-length case gives the pulse in cycle t+1.
- LOCKOUT:
  - locked=1 and busy=1; all inputs ignored.
  - A down-counter loads LOCKOUT_CYCLES-1 on entry.
  - At 0, go to IDLE with locked=0 and tries_left=MAX_TRIES.
- Bank contents changing during COMPARE: the value of rd in each cycle is used as is; no snapshot is taken.
- ra is 0 whenever the block is not in COMPARE. Register 0 is hard zero, so this read is harmless.
- Widths: lockout counter is $clog2(LOCKOUT_CYCLES) bits (min 1); cnt is 3 bits.

Decomposition:
- Shared package leitor_senha_pkg holds:
  - the state enum (IDLE, COMPARE, RESULT, LOCKOUT);
  - DATA_W=8 and ADDR_W=3, matching the bank geometry.
- One natural sub-module: contador_bloqueio, a loadable down-counter with a done flag, used for lockout timing.
- The digit buffer and FSM stay in the top level.

Test Plan:
- Bank regs1..4=3,1,4,1; enter 3,1,4,1; check → ra steps 1,2,3,4; open=1 exactly 5 cycles after check; tries_left stays 3.
- Same bank; enter 3,1,4,2; check → fail=1 at check+5; tries_left=2; buffer cleared; a following correct entry gives open and restores tries_left=3.
- Enter only 3,1 then check → fail at check+1; ra never leaves 0; tries_left=2.
- Three consecutive wrong codes → tries_left 3→2→1→0; locked=1 for exactly LOCKOUT_CYCLES=1000 cycles; digits and check are ignored during lockout; then locked=0 and tries_left=3.
- Enter 5 digits 3,1,4,1,9 → 5th digit is ignored; check gives open. Separately, assert digit_valid with check in the same cycle → digit dropped.
- Assert rst in the 2nd COMPARE cycle → no open/fail pulse; next cycle shows ra=0, busy=0, tries_left=3, and the entry buffer is empty.
